mux4_rr_arbiter: RTL

- Round-robin arbiter that shares one 4-input resource among four requesters, such as a shared writeback or memory port in the dual-issue pipeline.
- Drives the 2-bit select of the existing 4:1 data mux, plus a one-hot grant.
- Holds the grant for a multi-cycle transaction until the resource signals done, then rotates priority.
- Sits between the requesting pipeline stages and the shared resource/mux pair.

---
 rtl/arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 29 ++
 rtl/mux4_rr_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state type for the 4-way round-robin arbiter
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating priority encoder; search starts just after last_owner
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last_owner,
    output logic               any,
    output logic [SEL_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        // last_owner itself is visited last, so it only wins when alone
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = last_owner + SEL_W'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        onehot = any ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin owner select for a shared 4:1 resource mux
module mux4_rr_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 64
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic               start,
    output logic               timeout_err
);

    arb_state_e         state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               valid_q, valid_d;
    logic               start_q, start_d;
    logic               release_w;
    logic               pick_any;
    logic [SEL_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [SEL_W-1:0]   pick_last;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout_hit;

    assign timeout_hit = (state_q == ARB_BUSY) && (cnt_q == CNT_W'(TIMEOUT));
    assign release_w   = done || timeout_hit;
    assign timeout_err = err_q;

    always_comb begin
        err_d = err_q | timeout_hit;
        if (start_d)
            cnt_d = '0;
        else if (state_q == ARB_BUSY)
            cnt_d = cnt_q + CNT_W'(1);
        else
            cnt_d = cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign release_w   = done;
    assign timeout_err = 1'b0;
`endif

    // In the release cycle the finishing owner must already be lowest priority
    assign pick_last = (state_q == ARB_BUSY && release_w) ? sel_q : last_q;

    rr_pick u_pick (
        .req        (req),
        .last_owner (pick_last),
        .any        (pick_any),
        .idx        (pick_idx),
        .onehot     (pick_onehot)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        start_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_BUSY;
                    gnt_d   = pick_onehot;
                    sel_d   = pick_idx;
                    valid_d = 1'b1;
                    start_d = 1'b1;
                end
            end
            ARB_BUSY: begin
                if (release_w) begin
                    last_d = sel_q;
                    if (pick_any) begin
                        gnt_d   = pick_onehot;
                        sel_d   = pick_idx;
                        start_d = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(NUM_REQ - 1);
            gnt_q   <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            start_q <= start_d;
        end
    end

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign gnt_valid = valid_q;
    assign start     = start_q;

endmodule
